// File: rtl/bnn_pkg.sv
// Shared types for the binarized-neuron accumulator.
//   ACC_W        accumulator / result width (signed)
//   acc_t        signed accumulator word
//   neuron_res_t one queued result: binarized bit plus saturated total
//   sat_res_t    return type of sat_add: saturated sum plus overflow flag
//   sat_add      signed add of two acc_t values, clamped to the acc_t range
package bnn_pkg;

    localparam int ACC_W = 24;

    typedef logic signed [ACC_W-1:0] acc_t;

    typedef struct packed {
        logic bit_o;
        acc_t sum;
    } neuron_res_t;

    typedef struct packed {
        acc_t sum;
        logic ovf;
    } sat_res_t;

    // The sum is formed one bit wider. When its top two bits disagree, the
    // true result lies outside the acc_t range. Bit ACC_W then gives the
    // true sign, which selects the clamp direction.
    function automatic sat_res_t sat_add(acc_t a, acc_t b);
        logic [ACC_W:0] w;
        sat_res_t       r;
        w     = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        r.ovf = w[ACC_W] ^ w[ACC_W-1];
        if (r.ovf) begin
            r.sum = w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            r.sum = w[ACC_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/bnn_neuron_accum_if.sv
// Bus between the add64 tree / result consumer and bnn_neuron_accum.
//   in_valid/in_last/in_ready  chunk issue handshake (in_ready is a credit)
//   tree_sum                   signed add64 output, WIDTH_IN+11 bits
//   threshold                  binarization threshold
//   out_valid/out_ready        result handshake
//   out_bit/out_sum            head-of-queue result
// The master modport drives upstream and downstream. The slave modport is the accumulator.
interface bnn_neuron_accum_if #(
    parameter int WIDTH_IN = 8
);
    import bnn_pkg::*;

    logic                        in_valid;
    logic                        in_last;
    logic                        in_ready;
    logic signed [WIDTH_IN+10:0] tree_sum;
    acc_t                        threshold;
    logic                        out_valid;
    logic                        out_ready;
    logic                        out_bit;
    acc_t                        out_sum;

    modport master (
        output in_valid, in_last, tree_sum, threshold, out_ready,
        input  in_ready, out_valid, out_bit, out_sum
    );

    modport slave (
        input  in_valid, in_last, tree_sum, threshold, out_ready,
        output in_ready, out_valid, out_bit, out_sum
    );

endinterface

// File: rtl/bnn_sync_fifo.sv
// Generic synchronous FIFO with a first-word-fall-through head.
//   clk, rst  clock and synchronous active-high reset
//   push, din write port (ignored when full)
//   pop, dout read port; dout is the head taken combinationally from storage
//   count     number of entries held
//   empty     count == 0
//   full      count == DEPTH
// DEPTH must be a power of two, so the pointers wrap naturally.
module bnn_sync_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  T                        din,
    input  logic                    pop,
    output T                        dout,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty,
    output logic                    full
);

    localparam int AW = $clog2(DEPTH);

    T                mem_q [DEPTH];
    T                mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bnn_neuron_accum.sv
// Accumulates add64 partial sums over a variable number of 64-input chunks per
// neuron. It binarizes the total against a threshold and queues {bit, sum}.
//   clk, rst  clock and synchronous active-high reset
//   bus       slave side of bnn_neuron_accum_if (issue credit, tree_sum,
//             threshold, result handshake)
//   sat_err   sticky flag; set when any accumulation has saturated since reset
// The tree cannot be stalled. in_ready is a credit, and it only lets a final
// chunk in when the FIFO has room for every final chunk still in flight.
module bnn_neuron_accum
    import bnn_pkg::*;
#(
    parameter int WIDTH_IN   = 8,
    parameter int TREE_LAT   = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    bnn_neuron_accum_if.slave    bus,
    output logic                 sat_err
);

    localparam int TS_W = WIDTH_IN + 11;
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;

    // {v,last} delay line, aligned with tree_sum at stage TREE_LAT-1
    logic [TREE_LAT-1:0]   vld_pipe_q, vld_pipe_d;
    logic [TREE_LAT-1:0]   last_pipe_q, last_pipe_d;

    acc_t                  acc_q, acc_d;
    logic                  first_q, first_d;
    logic                  sat_err_q, sat_err_d;

    logic signed [TS_W-1:0] ts;
    logic                  dv, dlast;
    sat_res_t              s;
    logic                  push;
    neuron_res_t           push_res, head;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty, fifo_full;
    logic [7:0]            inflight_last;

    assign ts    = bus.tree_sum;
    assign dv    = vld_pipe_q[TREE_LAT-1];
    assign dlast = last_pipe_q[TREE_LAT-1];

    // Credit: each queued result and each final chunk in flight uses one slot.
    // This reads only registers, so it does not depend on in_valid or out_ready.
    always_comb begin
        inflight_last = '0;
        for (int i = 0; i < TREE_LAT; i++) begin
            inflight_last = inflight_last + 8'(vld_pipe_q[i] & last_pipe_q[i]);
        end
        bus.in_ready = (8'(fifo_count) + inflight_last) < 8'(FIFO_DEPTH);
    end

    always_comb begin
        vld_pipe_d[0]  = bus.in_valid & bus.in_ready;
        last_pipe_d[0] = bus.in_last;
        for (int i = 1; i < TREE_LAT; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            last_pipe_d[i] = last_pipe_q[i-1];
        end
    end

    // first_q marks the start of a neuron. The old acc is ignored there, so
    // leftover values cannot leak into the next neuron.
    always_comb begin
        s         = sat_add(acc_t'(ts), first_q ? acc_t'(0) : acc_q);
        acc_d     = acc_q;
        first_d   = first_q;
        sat_err_d = sat_err_q;
        if (dv) begin
            acc_d   = s.sum;
            first_d = dlast;
            if (s.ovf) sat_err_d = 1'b1;
        end
        push           = dv & dlast;
        push_res.bit_o = (s.sum >= bus.threshold);
        push_res.sum   = s.sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            acc_q       <= '0;
            first_q     <= 1'b1;
            sat_err_q   <= 1'b0;
        end else begin
            vld_pipe_q  <= vld_pipe_d;
            last_pipe_q <= last_pipe_d;
            acc_q       <= acc_d;
            first_q     <= first_d;
            sat_err_q   <= sat_err_d;
        end
    end

    bnn_sync_fifo #(
        .T     (neuron_res_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_res),
        .pop   (bus.out_valid & bus.out_ready),
        .dout  (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Outputs read zero while the queue is empty. This keeps idle outputs clean.
    assign bus.out_valid = ~fifo_empty;
    assign bus.out_bit   = fifo_empty ? 1'b0 : head.bit_o;
    assign bus.out_sum   = fifo_empty ? acc_t'(0) : head.sum;
    assign sat_err       = sat_err_q;

    // The credit rule guarantees a free slot for every final chunk that retires.
    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

endmodule

// File: tb/tb_bnn_neuron_accum.sv
// Directed bench for bnn_neuron_accum. A three-stage register chain stands in
// for the add64 tree. Expected results come from hand-computed vectors that
// are held in a small queue.
module tb_bnn_neuron_accum;
    import bnn_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic sat_err;

    bnn_neuron_accum_if #(.WIDTH_IN(8)) bus();

    bnn_neuron_accum #(
        .WIDTH_IN   (8),
        .TREE_LAT   (3),
        .FIFO_DEPTH (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .sat_err (sat_err)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int thr  = 0;
    int beat_sum = 0;
    int exp_sum[$];
    int exp_bit[$];

    // Tree stand-in: the sum that is presented with a beat appears on tree_sum 3 cycles later.
    logic signed [18:0] tp1, tp2;
    always @(posedge clk) begin
        tp1          <= bus.in_valid ? 19'(beat_sum) : '0;
        tp2          <= tp1;
        bus.tree_sum <= tp2;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model(input int s);
        exp_sum.push_back(s);
        exp_bit.push_back((s >= thr) ? 1 : 0);
    endtask

    task automatic send(input int s, input bit last);
        int g = 0;
        while (!bus.in_ready && g < 100) begin
            tick();
            g++;
        end
        if (g == 100) chk("send_credit", int'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        beat_sum     = s;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int g = 0;
        bus.out_ready = 1'b1;
        while (exp_sum.size() > 0 && g < 60) begin
            if (bus.out_valid) begin
                chk({tag, "_sum"}, int'(bus.out_sum), exp_sum.pop_front());
                chk({tag, "_bit"}, int'(bus.out_bit), exp_bit.pop_front());
            end
            tick();
            g++;
        end
        bus.out_ready = 1'b0;
        chk({tag, "_left"}, exp_sum.size(), 0);
        chk({tag, "_empty"}, int'(bus.out_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        bus.threshold = '0;
        repeat (3) tick();
        chk("rst_in_ready",  int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_bit",   int'(bus.out_bit), 0);
        chk("rst_out_sum",   int'(bus.out_sum), 0);
        chk("rst_sat_err",   int'(sat_err), 0);
        rst = 1'b0;
        tick();

        // 4-chunk neuron, total 125 vs threshold 100
        thr = 100; bus.threshold = 24'(thr);
        send(100, 0); send(-30, 0); send(50, 0); send(5, 1);
        tick(); tick();
        chk("t1_lat_early", int'(bus.out_valid), 0);
        tick();
        chk("t1_lat", int'(bus.out_valid), 1);
        model(125);
        drain("t1");

        // back-to-back single-chunk neurons
        thr = 0; bus.threshold = '0;
        send(-7, 1); model(-7);
        send(7, 1);  model(7);
        repeat (5) tick();
        drain("t2");

        // credit limit with the consumer stalled
        bus.in_valid = 1'b1; bus.in_last = 1'b1;
        n = 0; beat_sum = 1;
        for (int c = 0; c < 12; c++) begin
            if (bus.in_ready) begin
                model(beat_sum);
                n++;
            end
            tick();
            beat_sum = n + 1;
        end
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        chk("t3_accepted", n, 4);
        chk("t3_in_ready_low", int'(bus.in_ready), 0);
        chk("t3_out_valid", int'(bus.out_valid), 1);
        drain("t3");
        chk("t3_credit_back", int'(bus.in_ready), 1);
        send(5, 1); model(5);
        send(6, 1); model(6);
        repeat (5) tick();
        drain("t3b");

        // simultaneous push and pop with three entries held
        send(10, 1); model(10);
        send(11, 1); model(11);
        send(12, 1); model(12);
        repeat (5) tick();
        for (int k = 0; k < 12; k++) begin
            send(20 + k, 1); model(20 + k);
            tick(); tick();
            chk("t4_head_valid", int'(bus.out_valid), 1);
            chk("t4_head_sum", int'(bus.out_sum), exp_sum.pop_front());
            chk("t4_head_bit", int'(bus.out_bit), exp_bit.pop_front());
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
        drain("t4");

        // saturation: 34 * (2^18-1) exceeds 2^23-1
        chk("t5_sat_pre", int'(sat_err), 0);
        for (int i = 0; i < 34; i++) send(262143, i == 33);
        model(8388607);
        repeat (5) tick();
        chk("t5_sat_set", int'(sat_err), 1);
        drain("t5");
        send(-5, 1); model(-5);
        repeat (5) tick();
        chk("t5_sat_sticky", int'(sat_err), 1);
        drain("t5b");

        // reset with results queued and chunks in flight
        send(40, 1); model(40);
        send(41, 1); model(41);
        repeat (5) tick();
        send(1000, 0);
        repeat (5) tick();
        send(1000, 0); send(1000, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_out_valid", int'(bus.out_valid), 0);
        chk("t6_in_ready",  int'(bus.in_ready), 1);
        chk("t6_sat_clr",   int'(sat_err), 0);
        exp_sum.delete();
        exp_bit.delete();
        repeat (6) tick();
        chk("t6_quiet", int'(bus.out_valid), 0);
        send(3, 0); send(4, 1); model(7);
        repeat (5) tick();
        drain("t6");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
